// File: rtl/ahb_burst_write_master.sv
// AHB-Lite write master: drains a single-clock FWFT FIFO onto the bus as
// INCR4/8/16 or SINGLE transfers that never cross a 1 KB boundary.
module ahb_burst_write_master #(
    parameter int unsigned ADDRESSWIDTH  = 32,
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned FIFODEPTH     = 32,
    parameter int unsigned FIFODEPTH_LOG = 5,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      control_go,
    input  logic [ADDRESSWIDTH-1:0]   control_write_base,
    input  logic [ADDRESSWIDTH-1:0]   control_write_length,
    input  logic                      control_fixed_location,
    input  logic [2:0]                data_size,
    output logic                      control_done,
    output logic                      abort,
    input  logic                      user_write_buffer,
    input  logic [DATAWIDTH-1:0]      user_buffer_data,
    output logic                      user_buffer_full,
    output logic [FIFODEPTH_LOG:0]    fifo_level,
    output logic                      HSEL,
    input  logic                      HREADY,
    input  logic [1:0]                HRESP,
    output logic                      HREADYIN,
    output logic [ADDRESSWIDTH-1:0]   HADDR,
    output logic [DATAWIDTH-1:0]      HWDATA,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [1:0]                HTRANS
);
    localparam int unsigned AW    = ADDRESSWIDTH;
    localparam int unsigned LW    = FIFODEPTH_LOG + 1;
    localparam int unsigned LANES = DATAWIDTH / 8;
    localparam logic [2:0] MAX_SIZE = (DATAWIDTH == 64) ? 3'd3 : 3'd2;

    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_SEQ = 3'd2,
                           S_LAST = 3'd3, S_DONE = 3'd4, S_ERR  = 3'd5;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011,
                           B_INCR8  = 3'b101, B_INCR16 = 3'b111;

    // FIFO storage and pointers
    logic [DATAWIDTH-1:0]     mem [FIFODEPTH];
    logic [FIFODEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]            count, count_nxt;
    logic                     full_q, push, pop;
    logic [DATAWIDTH-1:0]     fifo_head, wdata_rep;

    // Bus / transfer state
    logic [2:0]    state, state_nxt;
    logic [1:0]    htrans, htrans_nxt;
    logic [2:0]    hburst, hburst_nxt;
    logic [AW-1:0] haddr, haddr_nxt;
    logic [AW-1:0] remaining, remaining_nxt;
    logic [4:0]    beats_left, beats_nxt;
    logic          fixed_q, fixed_nxt;
    logic [2:0]    hsize_q, hsize_nxt;
    logic          data_phase, data_phase_nxt;
    logic [DATAWIDTH-1:0] hwdata;
    logic          done_q, abort_q;
    logic [AW-1:0] step, go_step;
    logic          accept, err;
    logic [2:0]    burst_pick;
    logic [4:0]    burst_len;

    assign step      = AW'(1) << hsize_q;
    assign go_step   = AW'(1) << data_size;
    assign accept    = htrans[1] && HREADY;
    assign err       = data_phase && !HREADY && (HRESP == 2'b01);
    assign push      = user_write_buffer && !full_q;
    assign pop       = accept;
    assign count_nxt = count + LW'(push) - LW'(pop);
    assign fifo_head = mem[rd_ptr];

    function automatic logic burst_fits(input logic [4:0] n, input logic [2:0] sz,
                                        input logic [AW-1:0] rem, input logic [9:0] ofs,
                                        input logic [LW-1:0] lvl);
        logic [AW-1:0] span;
        logic [10:0]   end_ofs;
        span    = AW'(n) << sz;
        end_ofs = {1'b0, ofs} + (11'(n) << sz);
        return (rem >= span) && (LW'(n) <= lvl) && (end_ofs <= 11'd1024);
    endfunction

    // Largest legal burst for the next NONSEQ; ascending order lets the biggest win
    always_comb begin
        burst_pick = B_SINGLE;
        burst_len  = 5'd1;
        if (!fixed_q) begin
            if (burst_fits(5'd4, hsize_q, remaining, haddr[9:0], count)) begin
                burst_pick = B_INCR4;
                burst_len  = 5'd4;
            end
            if (MAX_BURST >= 8 && burst_fits(5'd8, hsize_q, remaining, haddr[9:0], count)) begin
                burst_pick = B_INCR8;
                burst_len  = 5'd8;
            end
            if (MAX_BURST >= 16 && burst_fits(5'd16, hsize_q, remaining, haddr[9:0], count)) begin
                burst_pick = B_INCR16;
                burst_len  = 5'd16;
            end
        end
    end

    // Narrow transfers replicate the active bytes across every lane
    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < int'(LANES); i++)
            wdata_rep[8*i +: 8] = fifo_head[8*(i & ((1 << hsize_q) - 1)) +: 8];
    end

    always_comb begin
        state_nxt      = state;
        htrans_nxt     = htrans;
        hburst_nxt     = hburst;
        haddr_nxt      = haddr;
        remaining_nxt  = remaining;
        beats_nxt      = beats_left;
        fixed_nxt      = fixed_q;
        hsize_nxt      = hsize_q;
        data_phase_nxt = accept ? 1'b1 : (HREADY ? 1'b0 : data_phase);
        if (accept) begin
            remaining_nxt = remaining - step;
            if (!fixed_q) haddr_nxt = haddr + step;
        end
        if (err) begin
            // errored beat was already debited at address acceptance; give it back
            state_nxt      = S_ERR;
            htrans_nxt     = T_IDLE;
            remaining_nxt  = remaining + step;
            data_phase_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (control_go) begin
                        haddr_nxt     = control_write_base;
                        remaining_nxt = control_write_length;
                        fixed_nxt     = control_fixed_location;
                        hsize_nxt     = data_size;
                        htrans_nxt    = T_IDLE;
                        if (data_size > MAX_SIZE || (control_write_length & (go_step - AW'(1))) != '0)
                            state_nxt = S_ERR;
                        else if (control_write_length == '0)
                            state_nxt = S_DONE;
                        else
                            state_nxt = S_ADDR;
                    end
                end
                S_ADDR, S_SEQ: begin
                    if (state == S_ADDR && htrans == T_IDLE) begin
                        if (count != '0) begin
                            htrans_nxt = T_NONSEQ;
                            hburst_nxt = burst_pick;
                            beats_nxt  = burst_len;
                        end
                    end else if (accept) begin
                        if (beats_left > 5'd1) begin
                            state_nxt  = S_SEQ;
                            htrans_nxt = T_SEQ;
                            beats_nxt  = beats_left - 5'd1;
                        end else begin
                            htrans_nxt = T_IDLE;
                            state_nxt  = (remaining != step) ? S_ADDR : S_LAST;
                        end
                    end
                end
                S_LAST: if (HREADY) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            htrans     <= T_IDLE;
            hburst     <= B_SINGLE;
            haddr      <= '0;
            remaining  <= '0;
            beats_left <= '0;
            fixed_q    <= 1'b0;
            hsize_q    <= 3'b010;
            data_phase <= 1'b0;
            hwdata     <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            htrans     <= htrans_nxt;
            hburst     <= hburst_nxt;
            haddr      <= haddr_nxt;
            remaining  <= remaining_nxt;
            beats_left <= beats_nxt;
            fixed_q    <= fixed_nxt;
            hsize_q    <= hsize_nxt;
            data_phase <= data_phase_nxt;
            if (accept) hwdata <= wdata_rep;
            done_q     <= (state_nxt == S_DONE);
            abort_q    <= (state_nxt == S_ERR);
            if (push) wr_ptr <= wr_ptr + FIFODEPTH_LOG'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFODEPTH_LOG'(1);
            count      <= count_nxt;
            full_q     <= (count_nxt == LW'(FIFODEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= user_buffer_data;
    end

    assign control_done     = done_q;
    assign abort            = abort_q;
    assign user_buffer_full = full_q;
    assign fifo_level       = count;
    assign HSEL             = 1'b1;
    assign HREADYIN         = HREADY;
    assign HADDR            = haddr;
    assign HWDATA           = hwdata;
    assign HWRITE           = 1'b1;
    assign HSIZE            = hsize_q;
    assign HBURST           = hburst;
    assign HPROT            = 4'b0011;
    assign HTRANS           = htrans;
endmodule

// File: tb/tb_ahb_burst_write_master.sv
// Randomised bench for ahb_burst_write_master: a transfer-level model predicts
// every accepted address beat and data phase, compared against a bus monitor.
module tb_ahb_burst_write_master;
    localparam int unsigned FD = 32;

    logic        clk, reset, control_go, control_fixed_location;
    logic [31:0] control_write_base, control_write_length;
    logic [2:0]  data_size;
    logic        control_done, abort, user_write_buffer, user_buffer_full;
    logic [31:0] user_buffer_data;
    logic [5:0]  fifo_level;
    logic        HSEL, HREADY, HREADYIN, HWRITE;
    logic [1:0]  HRESP, HTRANS;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_burst_write_master #(
        .ADDRESSWIDTH(32), .DATAWIDTH(32), .FIFODEPTH(32), .FIFODEPTH_LOG(5), .MAX_BURST(16)
    ) dut (
        .clk(clk), .reset(reset), .control_go(control_go),
        .control_write_base(control_write_base), .control_write_length(control_write_length),
        .control_fixed_location(control_fixed_location), .data_size(data_size),
        .control_done(control_done), .abort(abort), .user_write_buffer(user_write_buffer),
        .user_buffer_data(user_buffer_data), .user_buffer_full(user_buffer_full),
        .fifo_level(fifo_level), .HSEL(HSEL), .HREADY(HREADY), .HRESP(HRESP),
        .HREADYIN(HREADYIN), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model FIFO contents and the expected / observed beat streams
    logic [31:0] mfifo[$];
    logic [31:0] exp_addr[$], exp_data[$], act_addr[$], act_data[$];
    logic [2:0]  exp_burst[$], act_burst[$], act_size[$];
    logic [1:0]  exp_trans[$], act_trans[$];

    int cyc = 0, beat_cnt = 0, pend_idx = 0, last_data_cyc = -1, done_cyc = -1;
    int err_beat = -1, err_stage = 0, stall_pct = 0;
    bit pend = 0, done_seen = 0;

    // Slave responder + monitor; acceptance is judged with the HREADY it just drove
    initial begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (err_stage == 1) begin
                check_eq("err_htrans_idle", 64'(HTRANS), 64'(2'b00));
                check_eq("err_abort", 64'(abort), 64'(1));
                HREADY = 1'b1; HRESP = 2'b01; err_stage = 2; pend = 0;
            end else if (err_stage == 0 && pend && pend_idx == err_beat) begin
                HREADY = 1'b0; HRESP = 2'b01; err_stage = 1;
            end else begin
                HRESP  = 2'b00;
                HREADY = ($urandom_range(0, 99) >= stall_pct);
            end
            if (HREADY && pend) begin
                act_data.push_back(HWDATA);
                last_data_cyc = cyc;
                pend = 0;
            end
            if (HREADY && HTRANS[1]) begin
                act_addr.push_back(HADDR);
                act_burst.push_back(HBURST);
                act_trans.push_back(HTRANS);
                act_size.push_back(HSIZE);
                beat_cnt++;
                pend = 1;
                pend_idx = beat_cnt;
            end
            if (control_done && !done_seen) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        user_write_buffer = 1'b1;
        user_buffer_data  = w;
        if (mfifo.size() < FD) mfifo.push_back(w);
        tick();
        user_write_buffer = 1'b0;
    endtask

    function automatic logic [31:0] repl(input logic [31:0] w, input logic [2:0] sz);
        case (sz)
            3'd0:    return {4{w[7:0]}};
            3'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [2:0] burst_code(input int n);
        case (n)
            4:       return 3'b011;
            8:       return 3'b101;
            16:      return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Split the transfer into bursts from the rules, assuming no pushes meanwhile
    task automatic build_expected(input logic [31:0] base, input logic [31:0] len,
                                  input logic [2:0] sz, input bit fixed);
        logic [31:0] mf[$];
        logic [31:0] addr, rem, step;
        int lvl, n;
        mf = mfifo;
        addr = base; rem = len; step = 32'd1 << sz; lvl = mf.size();
        exp_addr.delete(); exp_data.delete(); exp_burst.delete(); exp_trans.delete();
        while (rem != 0 && mf.size() > 0) begin
            n = 1;
            for (int k = 16; k >= 4; k = k / 2)
                if (n == 1 && !fixed && rem >= 32'(k) * step && lvl >= k &&
                    (addr % 1024) + 32'(k) * step <= 1024)
                    n = k;
            for (int b = 0; b < n; b++) begin
                exp_addr.push_back(addr);
                exp_burst.push_back(burst_code(n));
                exp_trans.push_back(b == 0 ? 2'b10 : 2'b11);
                exp_data.push_back(repl(mf.pop_front(), sz));
                if (!fixed) addr = addr + step;
                rem = rem - step;
                lvl--;
            end
        end
    endtask

    task automatic start_go(input logic [31:0] base, input logic [31:0] len,
                            input logic [2:0] sz, input bit fixed, input int err_at);
        act_addr.delete(); act_data.delete(); act_burst.delete();
        act_trans.delete(); act_size.delete();
        beat_cnt = 0; pend = 0; err_beat = err_at; err_stage = 0;
        done_seen = 0; last_data_cyc = -1;
        control_write_base = base; control_write_length = len;
        data_size = sz; control_fixed_location = fixed;
        control_go = 1'b1;
        tick();
        control_go = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [31:0] len,
                            input logic [2:0] sz, input bit fixed, input int err_at);
        int na, nd, used;
        build_expected(base, len, sz, fixed);
        start_go(base, len, sz, fixed, err_at);
        for (int i = 0; i < 3000; i++) begin
            if (control_done || abort) break;
            tick();
        end
        check_eq("end_flags", 64'({control_done, abort}), (err_at < 0) ? 64'(2'b10) : 64'(2'b01));
        na = (err_at < 0) ? exp_addr.size() : err_at;
        nd = (err_at < 0) ? exp_data.size() : err_at - 1;
        check_eq("n_addr", 64'(act_addr.size()), 64'(na));
        check_eq("n_data", 64'(act_data.size()), 64'(nd));
        for (int i = 0; i < na && i < act_addr.size(); i++) begin
            check_eq($sformatf("haddr[%0d]", i),  64'(act_addr[i]),  64'(exp_addr[i]));
            check_eq($sformatf("hburst[%0d]", i), 64'(act_burst[i]), 64'(exp_burst[i]));
            check_eq($sformatf("htrans[%0d]", i), 64'(act_trans[i]), 64'(exp_trans[i]));
            check_eq($sformatf("hsize[%0d]", i),  64'(act_size[i]),  64'(sz));
        end
        for (int i = 0; i < nd && i < act_data.size(); i++)
            check_eq($sformatf("hwdata[%0d]", i), 64'(act_data[i]), 64'(exp_data[i]));
        if (err_at < 0 && nd > 0)
            check_eq("done_latency", 64'(done_cyc - last_data_cyc), 64'(1));
        used = na;
        for (int i = 0; i < used; i++) void'(mfifo.pop_front());
        tick();
        check_eq("fifo_level_after", 64'(fifo_level), 64'(mfifo.size()));
    endtask

    task automatic check_bad_go(input logic [31:0] len, input logic [2:0] sz);
        int lvl;
        lvl = mfifo.size();
        start_go(32'h40, len, sz, 1'b0, -1);
        tick(); tick();
        check_eq("badgo_abort", 64'(abort), 64'(1));
        check_eq("badgo_done", 64'(control_done), 64'(0));
        check_eq("badgo_no_beats", 64'(act_addr.size()), 64'(0));
        check_eq("badgo_level", 64'(fifo_level), 64'(lvl));
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_htrans"}, 64'(HTRANS), 64'(0));
        check_eq({pfx, "_haddr"}, 64'(HADDR), 64'(0));
        check_eq({pfx, "_hwdata"}, 64'(HWDATA), 64'(0));
        check_eq({pfx, "_hsize"}, 64'(HSIZE), 64'(3'b010));
        check_eq({pfx, "_hburst"}, 64'(HBURST), 64'(0));
        check_eq({pfx, "_done"}, 64'(control_done), 64'(0));
        check_eq({pfx, "_abort"}, 64'(abort), 64'(0));
        check_eq({pfx, "_level"}, 64'(fifo_level), 64'(0));
        check_eq({pfx, "_full"}, 64'(user_buffer_full), 64'(0));
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] step, base;
        int words, k;
        reset = 1'b1; control_go = 1'b0; control_write_base = '0; control_write_length = '0;
        control_fixed_location = 1'b0; data_size = 3'b010;
        user_write_buffer = 1'b0; user_buffer_data = '0;
        repeat (3) tick();
        check_reset_values("rst");
        check_eq("hsel", 64'(HSEL), 64'(1));
        check_eq("hprot", 64'(HPROT), 64'(4'b0011));
        check_eq("hreadyin", 64'(HREADYIN), 64'(HREADY));
        reset = 1'b0;
        tick();

        // One INCR16 from 0x100
        for (int i = 0; i < 16; i++) push_word($urandom);
        run_xfer(32'h100, 32'd64, 3'b010, 1'b0, -1);

        // Overfill, then split around the 1 KB boundary
        for (int i = 0; i < 33; i++) push_word($urandom);
        check_eq("fifo_full_level", 64'(fifo_level), 64'(32));
        check_eq("fifo_full_flag", 64'(user_buffer_full), 64'(1));
        run_xfer(32'h3F8, 32'd32, 3'b010, 1'b0, -1);
        check_eq("fifo_not_full", 64'(user_buffer_full), 64'(0));

        // Drain the leftover at a fixed address with stalls
        stall_pct = 30;
        run_xfer(32'h1000, 32'(mfifo.size() * 4), 3'b010, 1'b1, -1);

        // Byte write with lane replication
        stall_pct = 0;
        push_word(32'h0000_00A5);
        run_xfer(32'h3, 32'd1, 3'b000, 1'b0, -1);
        if (act_data.size() > 0) check_eq("byte_repl", 64'(act_data[0]), 64'(32'hA5A5_A5A5));

        // Error response on beat 3 of an INCR8; unsent words stay queued
        for (int i = 0; i < 8; i++) push_word($urandom);
        run_xfer(32'h200, 32'd32, 3'b010, 1'b0, 3);

        // Zero length finishes immediately; bad size / misaligned length abort
        run_xfer(32'h80, 32'd0, 3'b010, 1'b0, -1);
        check_bad_go(32'd8, 3'b011);
        check_bad_go(32'd6, 3'b010);

        // Reset in the middle of a stalled burst, then a clean restart
        for (int i = 0; i < 16; i++) push_word($urandom);
        stall_pct = 30;
        start_go(32'h100, 32'd64, 3'b010, 1'b0, -1);
        for (int i = 0; i < 200 && beat_cnt < 5; i++) tick();
        check_eq("mid_reached", 64'(beat_cnt >= 5), 64'(1));
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        mfifo.delete();
        pend = 0;
        tick();
        for (int i = 0; i < 8; i++) push_word($urandom);
        run_xfer(32'h40, 32'd32, 3'b010, 1'b0, -1);

        // Randomised transfers
        for (int t = 0; t < 25; t++) begin
            stall_pct = 30 * $urandom_range(0, 2);
            k = $urandom_range(0, FD - mfifo.size());
            for (int i = 0; i < k; i++) push_word($urandom);
            if (mfifo.size() == 0) push_word($urandom);
            sz    = 3'($urandom_range(0, 2));
            step  = 32'd1 << sz;
            words = $urandom_range(1, mfifo.size());
            base  = $urandom & ~(step - 32'd1);
            run_xfer(base, 32'(words) * step, sz, ($urandom_range(0, 3) == 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
